gate_bist_driver: RTL and testbench
===================================

// Module: gate_bist_driver
// PURPOSE
//  Stimulus/checker end of a combinational gate under test: drives every input
//  pattern onto the gate, samples its response, and compares it with the expected AND.
//  Sits beside the gate on the same clock; reports error count, first failing
//  pattern and pass/fail to a host through a start/done handshake.
// PARAMETERS
//  N_IN    2  gate input width; patterns 0 .. 2^N_IN-1
//  SETTLE  1  wait cycles after a new pattern before sampling (>=1)
//  ERR_W   8  error counter width (saturating)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin run; sampled only in IDLE
//  pat         out  N_IN   pattern driven to gate inputs
//  resp        in   1      gate output
//  busy        out  1      high from cycle after accepted start until FINISH
//  done        out  1      one-cycle pulse in FINISH
//  err_cnt     out  ERR_W  mismatches this run, saturating at 2^ERR_W-1
//  fail_valid  out  1      at least one mismatch this run
//  first_fail  out  N_IN   pattern of first mismatch (valid when fail_valid)
//  pass        out  1      last completed run had zero mismatches
// BEHAVIOUR
//  Reset: state IDLE; pat, err_cnt, first_fail = 0; busy, done, fail_valid, pass = 0.
//  Reset mid-run aborts immediately; no done pulse; results cleared.
//  FSM: IDLE -> SETTLE -> CHECK -> (SETTLE | FINISH) -> IDLE.
//   IDLE: start=1 -> SETTLE; pat<=0, wait counter<=SETTLE; err_cnt, fail_valid,
//         first_fail, pass cleared.
//   SETTLE: counter decrements; at 1 -> CHECK. Occupies SETTLE cycles.
//   CHECK: expected = &pat; on resp != expected, err_cnt++ (saturate) and, if
//     !fail_valid, first_fail<=pat, fail_valid<=1. pat==all-ones -> FINISH,
//     else pat<=pat+1 and counter reloaded -> SETTLE.
//   FINISH: done=1 one cycle; pass<=(no mismatch in run); -> IDLE.
//  Latency: start accepted at cycle t -> done at t+1+2^N_IN*(SETTLE+1).
//  start ignored in SETTLE, CHECK, FINISH; holding start in IDLE after FINISH
//   starts a new run the following cycle.
//  pat, err_cnt, first_fail, fail_valid, pass hold their values in IDLE until next start.
//  Counters: wait counter width clog2(SETTLE+1); pat wrap never occurs (FINISH first).
// CONFIGURATION
//  GATE_BIST_MISR_EN defined: adds output signature[15:0]; seeded 16'hFFFF at start;
//   each CHECK: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {15'b0, resp};
//   held after FINISH; reset to 16'h0000.
//  Not defined: no signature port, no MISR logic; all else identical.
// STRUCTURE
//  gate_bist_defs.vh: state encodings, SIG_W=16, MISR tap constant, SEED=16'hFFFF.
//  Sub-module gate_bist_misr (clk, rst, seed_ld, shift_en, din, sig), instantiated
//   only under GATE_BIST_MISR_EN; FSM, counters and compare stay in top.
// TESTING (N_IN=2, SETTLE=1, ERR_W=8 unless noted; gate model registers resp 0 cycles)
//  1 Good AND, start pulse at cycle 0 -> pat 0,1,2,3 held 2 cycles each from
//    cycle 1; done at cycle 9; err_cnt=0, fail_valid=0, pass=1.
//  2 Stuck-at-0 gate -> err_cnt=1, first_fail=2'b11, fail_valid=1, pass=0.
//  3 Stuck-at-1 gate -> err_cnt=3, first_fail=2'b00; with ERR_W=1 -> err_cnt=1.
//  4 rst high at cycle 4 mid-run -> cycle 5: busy=0, pat=0, err_cnt=0; no done;
//    next start completes normal 9-cycle run.
//  5 start held high continuously -> runs back-to-back, done every 10 cycles;
//    extra start pulses during busy have no effect on timing or results.
//  6 GATE_BIST_MISR_EN: good gate signature equals golden model; flipping one
//    response (pattern 2) yields a different signature; reset gives 16'h0000.

Source files
------------

// File: rtl/gate_bist_driver_pkg.sv
// Shared types and constants for the gate BIST driver and its optional MISR.
package gate_bist_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int          SIG_W     = 16;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  // Feedback taps: bits 15, 13, 12, 10.
  localparam logic [15:0] MISR_TAPS = 16'hB400;

  // One MISR step: shift left, feed back the tap parity, fold the response into bit 0.
  function automatic logic [SIG_W-1:0] misr_step(logic [SIG_W-1:0] sig, logic din);
    return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {{(SIG_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/gate_bist_driver_if.sv
// Host/gate-side bundle of the BIST driver. The signature port exists only
// when GATE_BIST_MISR_EN is defined.
interface gate_bist_driver_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
) ();
  logic             start;
  logic [N_IN-1:0]  pat;
  logic             resp;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [N_IN-1:0]  first_fail;
  logic             pass;
`ifdef GATE_BIST_MISR_EN
  logic [15:0]      signature;
`endif

  // Host and gate model side.
  modport master (
    output start, resp,
    input  pat, busy, done, err_cnt, fail_valid, first_fail, pass
`ifdef GATE_BIST_MISR_EN
    , input signature
`endif
  );

  // The BIST driver itself.
  modport slave (
    input  start, resp,
    output pat, busy, done, err_cnt, fail_valid, first_fail, pass
`ifdef GATE_BIST_MISR_EN
    , output signature
`endif
  );
endinterface

// File: rtl/gate_bist_misr.sv
// 16-bit multiple-input signature register compacting the gate responses.
// Only instantiated when GATE_BIST_MISR_EN is defined.
module gate_bist_misr
  import gate_bist_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_ld,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  // Seed on run start, fold one response per check cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst)           sig <= '0;
    else if (seed_ld)  sig <= MISR_SEED;
    else if (shift_en) sig <= misr_step(sig, din);
  end

endmodule

// File: rtl/gate_bist_driver.sv
// Exhaustive-pattern BIST driver for a combinational AND gate under test.
// Walks every input pattern, waits SETTLE cycles, compares the response with
// the expected AND, and reports error count / first failure / pass to the host.
// Optional feature: define GATE_BIST_MISR_EN to add a 16-bit response signature.
module gate_bist_driver
  import gate_bist_driver_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  gate_bist_driver_if.slave  bus
);

  localparam int              CNT_W    = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]  PAT_LAST = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic [N_IN-1:0]  pat_q;
  logic [ERR_W-1:0] err_q;
  logic             fv_q;
  logic [N_IN-1:0]  ff_q;
  logic             pass_q;
  logic             mismatch;
  logic             accept;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign mismatch = bus.resp != (&pat_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (wcnt == CNT_W'(1)) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = (pat_q == PAT_LAST) ? ST_FINISH : ST_SETTLE;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ST_SETTLE, ST_CHECK: bus.busy = 1'b1;
      ST_FINISH:           bus.done = 1'b1;
      default:             ;
    endcase
  end

  // Pattern walk, settle counter and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      wcnt   <= '0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      ff_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          pat_q  <= '0;
          wcnt   <= CNT_LOAD;
          err_q  <= '0;
          fv_q   <= 1'b0;
          ff_q   <= '0;
          pass_q <= 1'b0;
        end
        ST_SETTLE: wcnt <= wcnt - CNT_W'(1);
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (!fv_q) begin
              ff_q <= pat_q;
              fv_q <= 1'b1;
            end
          end
          // Last pattern goes straight to FINISH, so pat never wraps.
          if (pat_q != PAT_LAST) begin
            pat_q <= pat_q + N_IN'(1);
            wcnt  <= CNT_LOAD;
          end
        end
        ST_FINISH: pass_q <= !fv_q;
        default: ;
      endcase
    end
  end

  assign bus.pat        = pat_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail = ff_q;
  assign bus.pass       = pass_q;

`ifdef GATE_BIST_MISR_EN
  logic [SIG_W-1:0] sig;

  gate_bist_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .seed_ld  (accept),
    .shift_en (state == ST_CHECK),
    .din      (bus.resp),
    .sig      (sig)
  );

  assign bus.signature = sig;
`else
  // accept only feeds the signature seed.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gate_bist_driver.sv
// Bench for gate_bist_driver: a gate model with per-pattern fault mask,
// checked against a per-run model of error count, first failure and pass.
module tb_gate_bist_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_bist_driver_if #(.N_IN(2), .ERR_W(8)) ifa ();
  gate_bist_driver_if #(.N_IN(2), .ERR_W(1)) ifb ();

  // Gate under test: an AND with the response inverted on patterns set in mask.
  assign ifa.resp  = (&ifa.pat) ^ mask[ifa.pat];
  assign ifb.resp  = (&ifb.pat) ^ mask[ifb.pat];
  assign ifb.start = ifa.start;

  gate_bist_driver #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(ifa));
  gate_bist_driver #(.N_IN(2), .SETTLE(1), .ERR_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: number of faulty patterns and the lowest one.
  function automatic int model_err(input logic [3:0] m);
    int n = 0;
    for (int p = 0; p < 4; p++) if (m[p]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [3:0] m);
    for (int p = 0; p < 4; p++) if (m[p]) return p;
    return 0;
  endfunction

`ifdef GATE_BIST_MISR_EN
  function automatic logic [15:0] model_sig(input logic [3:0] m);
    logic [15:0] s = 16'hFFFF;
    logic [1:0]  pv;
    logic        r;
    for (int p = 0; p < 4; p++) begin
      pv = 2'(p);
      r  = (&pv) ^ m[p];
      s  = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {15'b0, r};
    end
    return s;
  endfunction
`endif

  // Compare the held results (sampled in the idle cycle after done) with the model.
  task automatic chk_results(input string tag, input logic [3:0] m);
    int e = model_err(m);
    chk({tag, ".err"},   32'(ifa.err_cnt),    32'(e));
    chk({tag, ".err1"},  32'(ifb.err_cnt),    32'(e > 0));
    chk({tag, ".fv"},    32'(ifa.fail_valid), 32'(e > 0));
    chk({tag, ".first"}, 32'(ifa.first_fail), 32'(model_first(m)));
    chk({tag, ".pass"},  32'(ifa.pass),       32'(e == 0));
    chk({tag, ".done"},  32'(ifa.done),       32'd0);
`ifdef GATE_BIST_MISR_EN
    chk({tag, ".sig"},   32'(ifa.signature),  32'(model_sig(m)));
`endif
  endtask

  // One start pulse; checks pattern walk, busy, latency, then results.
  task automatic run_one(input string tag, input logic [3:0] m);
    int n;
    mask = m;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk) ifa.start = 1'b0;
    while (!ifa.done && n < 40) begin
      if (n <= 8) begin
        chk({tag, ".pat"},  32'(ifa.pat),  32'((n - 1) / 2));
        chk({tag, ".busy"}, 32'(ifa.busy), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"},   32'(n), 32'd9);
    chk({tag, ".dbusy"}, 32'(ifa.busy), 32'd0);
    @(negedge clk);
    chk_results(tag, m);
  endtask

  initial begin
    int dones;
    int exp_done;
    logic [3:0] m;

    rst = 1'b1;
    ifa.start = 1'b0;
    mask = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pat",  32'(ifa.pat),        32'd0);
    chk("rst.err",  32'(ifa.err_cnt),    32'd0);
    chk("rst.busy", 32'(ifa.busy),       32'd0);
    chk("rst.done", 32'(ifa.done),       32'd0);
    chk("rst.fv",   32'(ifa.fail_valid), 32'd0);
    chk("rst.ff",   32'(ifa.first_fail), 32'd0);
    chk("rst.pass", 32'(ifa.pass),       32'd0);
`ifdef GATE_BIST_MISR_EN
    chk("rst.sig",  32'(ifa.signature),  32'd0);
`endif
    rst = 1'b0;

    run_one("good", 4'b0000);
    run_one("sa0",  4'b1000);
    run_one("sa1",  4'b0111);
`ifdef GATE_BIST_MISR_EN
    run_one("flip2", 4'b0100);
`endif

    // Reset mid-run: abort, clear results, no done afterwards.
    mask = 4'b0111;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk) ifa.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.busy", 32'(ifa.busy),       32'd0);
    chk("mrst.pat",  32'(ifa.pat),        32'd0);
    chk("mrst.err",  32'(ifa.err_cnt),    32'd0);
    chk("mrst.fv",   32'(ifa.fail_valid), 32'd0);
    chk("mrst.done", 32'(ifa.done),       32'd0);
`ifdef GATE_BIST_MISR_EN
    chk("mrst.sig",  32'(ifa.signature),  32'd0);
`endif
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.done) dones++;
    end
    chk("mrst.nodone", 32'(dones), 32'd0);
    run_one("after_rst", 4'b0000);

    // start held high: back-to-back runs, done every 10 cycles.
    m = 4'($urandom_range(0, 15));
    mask = m;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk);
    exp_done = 9;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ifa.done) begin
        chk("b2b.done_at", 32'(n), 32'(exp_done));
        exp_done += 10;
      end
      if (n == 39) ifa.start = 1'b0;
      if (n % 10 == 0) chk_results("b2b", m);
    end
    chk("b2b.count", 32'(exp_done), 32'd49);

    // Random fault masks.
    for (int i = 0; i < 8; i++) run_one("rand", 4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
